// File: rtl/mac_pkg.sv
// Shared definitions for the MAC operand stream feeder: word width, the
// NaN end-of-stream marker, FSM state encodings and a float32 NaN test.
package mac_pkg;

    localparam int DATA_WIDTH = 32;

    // Signalling-NaN pattern the MAC recognises as "end of operand stream".
    localparam logic [31:0] NAN_SENTINEL = 32'h7F90_0000;

    // Coefficient channel: idle, walking the table downwards, sending marker.
    typedef enum logic [1:0] {
        C_IDLE   = 2'd0,
        C_STREAM = 2'd1,
        C_TERM   = 2'd2
    } coeff_state_e;

    // Sample channel: forwarding samples, or closing a frame with the marker.
    typedef enum logic {
        S_PASS = 1'b0,
        S_TERM = 1'b1
    } sample_state_e;

    // IEEE-754 single precision NaN: exponent all ones, mantissa nonzero.
    function automatic logic is_nan(input logic [31:0] word);
        return (&word[30:23]) && (|word[22:0]);
    endfunction

endpackage

// File: rtl/mac_stream_hold.sv
// One-word output holding register for a FIFO write port. A word loaded
// here is presented with wr_o=1 and held unchanged until the FIFO takes it
// (wr_o=1 and full_i=0 at a clock edge). ready_o tells the producer a new
// word can be loaded this cycle, either into an empty slot or as a direct
// replacement for the word being accepted.
module mac_stream_hold #(
    parameter int WIDTH = 32
) (
    input  logic             clk_i,
    input  logic             rstn_i,
    input  logic             load_i,
    input  logic [WIDTH-1:0] load_data_i,
    input  logic             full_i,
    output logic             wr_o,
    output logic [WIDTH-1:0] data_o,
    output logic             ready_o
);

    logic             wr_q;
    logic             wr_d;
    logic [WIDTH-1:0] data_q;
    logic [WIDTH-1:0] data_d;

    assign ready_o = !wr_q || !full_i;
    assign wr_o    = wr_q;
    assign data_o  = data_q;

    // Next word: a load wins, otherwise an accepted word empties the slot.
    always_comb begin
        wr_d   = wr_q;
        data_d = data_q;
        if (load_i) begin
            wr_d   = 1'b1;
            data_d = load_data_i;
        end else if (wr_q && !full_i) begin
            wr_d = 1'b0;
        end
    end

    // Holding register; cleared so the FIFO port is quiet out of reset.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            wr_q   <= 1'b0;
            data_q <= '0;
        end else begin
            wr_q   <= wr_d;
            data_q <= data_d;
        end
    end

endmodule

// File: rtl/mac_stream_feeder.sv
// Producer for the MAC's two operand FIFOs. The coefficient channel streams
// a programmable polynomial table highest degree first followed by a NaN
// end marker; the sample channel forwards a valid/ready stream and closes
// every frame with the same marker. Both honour FIFO-full back-pressure.
// Optional build macro MAC_FEEDER_NAN_SCRUB_EN: incoming NaN samples are
// replaced by +0.0 and flagged on the sticky nan_err_o.
module mac_stream_feeder
    import mac_pkg::*;
#(
    parameter int DATA_WIDTH  = mac_pkg::DATA_WIDTH,
    parameter int COEFF_DEPTH = 26,
    parameter int CADDR_W     = $clog2(COEFF_DEPTH)
) (
    input  logic                  clk_i,
    input  logic                  rstn_i,
    input  logic                  cfg_we_i,
    input  logic [CADDR_W-1:0]    cfg_addr_i,
    input  logic [DATA_WIDTH-1:0] cfg_data_i,
    input  logic [CADDR_W:0]      num_coeffs_i,
    input  logic                  start_i,
    output logic                  coeff_busy_o,
    output logic                  coeff_done_o,
    input  logic                  s_valid_i,
    output logic                  s_ready_o,
    input  logic [DATA_WIDTH-1:0] s_data_i,
    input  logic                  s_last_i,
    output logic                  frame_done_o,
    output logic [DATA_WIDTH-1:0] signal_fifo_o,
    output logic                  signal_wr_o,
    input  logic                  signal_full_i,
    output logic [DATA_WIDTH-1:0] coeff_fifo_o,
    output logic                  coeff_wr_o,
    input  logic                  coeff_full_i,
    output logic                  nan_err_o
);

    localparam logic [DATA_WIDTH-1:0] SENTINEL  = DATA_WIDTH'(NAN_SENTINEL);
    localparam logic [CADDR_W:0]      DEPTH_CNT = (CADDR_W + 1)'(COEFF_DEPTH);

    // ------------------------------------------------------------------
    // Coefficient table
    // ------------------------------------------------------------------
    logic [DATA_WIDTH-1:0] table_q [COEFF_DEPTH];
    logic [DATA_WIDTH-1:0] table_d [COEFF_DEPTH];

    coeff_state_e          c_state_q;
    coeff_state_e          c_state_d;
    logic [CADDR_W-1:0]    c_idx_q;
    logic [CADDR_W-1:0]    c_idx_d;
    logic                  c_load;
    logic [DATA_WIDTH-1:0] c_load_data;
    logic                  c_hold_ready;
    logic                  c_accept;
    logic [CADDR_W:0]      n_clamped;

    // Writes are only taken while idle so a running stream sees a stable table.
    always_comb begin
        table_d = table_q;
        if (cfg_we_i && (c_state_q == C_IDLE) && ({1'b0, cfg_addr_i} < DEPTH_CNT)) begin
            table_d[cfg_addr_i] = cfg_data_i;
        end
    end

    // Table storage, cleared to 0.0 on reset.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            table_q <= '{default: '0};
        end else begin
            table_q <= table_d;
        end
    end

    // ------------------------------------------------------------------
    // Coefficient channel FSM
    // ------------------------------------------------------------------
    assign n_clamped    = (num_coeffs_i > DEPTH_CNT) ? DEPTH_CNT : num_coeffs_i;
    assign c_accept     = coeff_wr_o && !coeff_full_i;
    assign coeff_busy_o = (c_state_q != C_IDLE);
    assign coeff_done_o = (c_state_q == C_TERM) && c_accept;

    // Walk the table from degree n-1 down to 0, then hand over to the marker.
    always_comb begin
        c_state_d   = c_state_q;
        c_idx_d     = c_idx_q;
        c_load      = 1'b0;
        c_load_data = '0;
        case (c_state_q)
            C_IDLE: begin
                if (start_i && c_hold_ready) begin
                    c_load = 1'b1;
                    if (n_clamped == '0) begin
                        c_load_data = SENTINEL;
                        c_state_d   = C_TERM;
                    end else begin
                        c_idx_d     = CADDR_W'(n_clamped - 1'b1);
                        c_load_data = table_q[c_idx_d];
                        c_state_d   = C_STREAM;
                    end
                end
            end
            C_STREAM: begin
                if (c_accept) begin
                    c_load = 1'b1;
                    if (c_idx_q == '0) begin
                        c_load_data = SENTINEL;
                        c_state_d   = C_TERM;
                    end else begin
                        c_idx_d     = c_idx_q - 1'b1;
                        c_load_data = table_q[c_idx_d];
                    end
                end
            end
            C_TERM: begin
                if (c_accept) begin
                    c_state_d = C_IDLE;
                end
            end
            default: begin
                c_state_d = C_IDLE;
            end
        endcase
    end

    // Coefficient FSM state and table pointer.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            c_state_q <= C_IDLE;
            c_idx_q   <= '0;
        end else begin
            c_state_q <= c_state_d;
            c_idx_q   <= c_idx_d;
        end
    end

    mac_stream_hold #(
        .WIDTH (DATA_WIDTH)
    ) u_coeff_hold (
        .clk_i       (clk_i),
        .rstn_i      (rstn_i),
        .load_i      (c_load),
        .load_data_i (c_load_data),
        .full_i      (coeff_full_i),
        .wr_o        (coeff_wr_o),
        .data_o      (coeff_fifo_o),
        .ready_o     (c_hold_ready)
    );

    // ------------------------------------------------------------------
    // Sample channel FSM
    // ------------------------------------------------------------------
    sample_state_e         s_state_q;
    sample_state_e         s_state_d;
    logic                  s_sent_q;
    logic                  s_sent_d;
    logic                  rdy_en_q;
    logic                  rdy_en_d;
    logic                  s_load;
    logic [DATA_WIDTH-1:0] s_load_data;
    logic                  s_hold_ready;
    logic                  s_accept;
    logic                  s_handshake;
    logic [DATA_WIDTH-1:0] sample_word;

    assign s_ready_o    = rdy_en_q && (s_state_q == S_PASS) && s_hold_ready;
    assign s_handshake  = s_valid_i && s_ready_o;
    assign s_accept     = signal_wr_o && !signal_full_i;
    assign frame_done_o = (s_state_q == S_TERM) && s_sent_q && s_accept;

`ifdef MAC_FEEDER_NAN_SCRUB_EN
    logic nan_err_q;
    logic nan_err_d;
    logic sample_is_nan;

    assign sample_is_nan = is_nan(32'(s_data_i));
    assign sample_word   = sample_is_nan ? '0 : s_data_i;
    assign nan_err_o     = nan_err_q;

    // Sticky flag: any NaN accepted from upstream since reset.
    always_comb begin
        nan_err_d = nan_err_q | (s_handshake && sample_is_nan);
    end

    // NaN error flag register.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            nan_err_q <= 1'b0;
        end else begin
            nan_err_q <= nan_err_d;
        end
    end
`else
    assign sample_word = s_data_i;
    assign nan_err_o   = 1'b0;
`endif

    // Forward samples; after the frame's last one, queue the marker behind it.
    always_comb begin
        s_state_d   = s_state_q;
        s_sent_d    = s_sent_q;
        rdy_en_d    = 1'b1;
        s_load      = 1'b0;
        s_load_data = '0;
        case (s_state_q)
            S_PASS: begin
                if (s_handshake) begin
                    s_load      = 1'b1;
                    s_load_data = sample_word;
                    s_sent_d    = 1'b0;
                    if (s_last_i) begin
                        s_state_d = S_TERM;
                    end
                end
            end
            S_TERM: begin
                if (!s_sent_q && s_hold_ready) begin
                    s_load      = 1'b1;
                    s_load_data = SENTINEL;
                    s_sent_d    = 1'b1;
                end else if (s_sent_q && s_accept) begin
                    s_state_d = S_PASS;
                    s_sent_d  = 1'b0;
                end
            end
            default: begin
                s_state_d = S_PASS;
            end
        endcase
    end

    // Sample FSM state; ready stays low until the first cycle after reset.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            s_state_q <= S_PASS;
            s_sent_q  <= 1'b0;
            rdy_en_q  <= 1'b0;
        end else begin
            s_state_q <= s_state_d;
            s_sent_q  <= s_sent_d;
            rdy_en_q  <= rdy_en_d;
        end
    end

    mac_stream_hold #(
        .WIDTH (DATA_WIDTH)
    ) u_signal_hold (
        .clk_i       (clk_i),
        .rstn_i      (rstn_i),
        .load_i      (s_load),
        .load_data_i (s_load_data),
        .full_i      (signal_full_i),
        .wr_o        (signal_wr_o),
        .data_o      (signal_fifo_o),
        .ready_o     (s_hold_ready)
    );

endmodule

// File: doc/mac_stream_feeder.md
Name: mac_stream_feeder

Overview:
- Producer side of the MAC operand streams: drives the MAC's signal-word and coefficient-word FIFO write ports, IEEE-754 single precision.
- Coefficient channel: on start, streams a programmable Taylor/Horner coefficient table, highest degree first, then a NaN end marker.
- Sample channel: forwards a valid/ready sample stream and appends the NaN end marker after the last sample of each frame.
- Sits between the activation-function front end (SeLU/Sigmoid/Swish/GeLU) and the mac block; honours FIFO full back-pressure.

Parameters:
- DATA_WIDTH, 32, operand word width (float32).
- COEFF_DEPTH, 26, coefficient table entries (max polynomial degree + 1).
- CADDR_W, $clog2(COEFF_DEPTH), table address / count width.

Ports:
- clk_i  in  1  clock, rising edge.
- rstn_i  in  1  reset, asynchronous, active-low.
- cfg_we_i  in  1  coefficient table write strobe.
- cfg_addr_i  in  CADDR_W  table index (= polynomial degree).
- cfg_data_i  in  DATA_WIDTH  coefficient value.
- num_coeffs_i  in  CADDR_W+1  coefficients to stream, sampled on start_i.
- start_i  in  1  start coefficient stream (pulse).
- coeff_busy_o  out  1  coefficient channel active.
- coeff_done_o  out  1  1-cycle pulse when coefficient end marker is accepted.
- s_valid_i  in  1  sample valid.
- s_ready_o  out  1  sample ready.
- s_data_i  in  DATA_WIDTH  sample value.
- s_last_i  in  1  last sample of frame.
- frame_done_o  out  1  1-cycle pulse when sample end marker is accepted.
- signal_fifo_o  out  DATA_WIDTH  sample word to MAC.
- signal_wr_o  out  1  sample word valid / FIFO write.
- signal_full_i  in  1  sample FIFO full.
- coeff_fifo_o  out  DATA_WIDTH  coefficient word to MAC.
- coeff_wr_o  out  1  coefficient word valid / FIFO write.
- coeff_full_i  in  1  coefficient FIFO full.
- nan_err_o  out  1  sticky: NaN sample seen on input.

Behaviour:
- Reset: all outputs 0; table cleared to 0; both channels IDLE. Reset mid-stream aborts it; no end marker is sent.
- Word transfer on either output: a word is accepted at a clock edge where wr_o=1 and full_i=0.
- While full_i=1, wr_o and data hold unchanged until the word is accepted; wr_o never drops with a word pending.
- End marker: NAN_SENTINEL = 32'h7F90_0000.
- Coefficient FSM, IDLE -> STREAM -> TERM -> IDLE:
  - start_i in IDLE latches n = min(num_coeffs_i, COEFF_DEPTH) and sets idx = n-1.
  - First coeff_wr_o is asserted the cycle after start_i.
  - STREAM presents table[idx], decrementing on each accept, down to index 0.
  - TERM presents the sentinel. On its accept: coeff_done_o pulses and the FSM returns to IDLE.
  - n=0: go directly to TERM.
  - start_i while busy: ignored.
  - coeff_busy_o = state != IDLE.
- cfg_we_i writes take effect next cycle and are dropped while coeff_busy_o=1. An out-of-range cfg_addr_i is ignored.
- Sample FSM, PASS -> TERM -> PASS:
  - s_ready_o = (state==PASS) && (!signal_wr_o || !signal_full_i), a one-deep register with pass-through on accept.
  - A handshake at cycle t gives signal_wr_o=1 with that data at t+1; back-to-back throughput is 1 word/cycle.
  - A handshake with s_last_i=1 moves the FSM to TERM: s_ready_o=0, and the sentinel is presented immediately after the last sample is accepted.
  - On sentinel accept: frame_done_o pulses, then back to PASS.
- The two channels are fully independent; simultaneous accepts on both are legal.
- Float handling is pass-through except as defined under Optional Feature.

Optional Feature:
- Macro: MAC_FEEDER_NAN_SCRUB_EN.
- Defined: an incoming sample with exponent all-ones and nonzero mantissa is replaced by +0.0 (32'h0000_0000), and nan_err_o is set sticky until reset. This prevents a false end marker inside a frame.
- Undefined: samples pass unchanged and nan_err_o is tied 0.

Decomposition:
- Package mac_pkg holds:
  - DATA_WIDTH
  - NAN_SENTINEL
  - the coefficient FSM state constants
  - the sample FSM state constants
  - an is_nan function
- One natural sub-module, mac_stream_hold: a one-word output hold register with wr/full handshake. It is instantiated once per channel.

Test Plan:
- Load exp Taylor table (table[0]=table[1]=32'h3F800000, table[2]=32'h3F000000, table[3]=32'h3E2AAAAB); num_coeffs_i=4; start_i; coeff_full_i=0 -> coeff_fifo_o sequence 3E2AAAAB, 3F000000, 3F800000, 3F800000, 7F900000 on 5 consecutive cycles starting 1 cycle after start_i; coeff_done_o pulses on the last one.
- Samples C0A00000, BE308D3D, 40A00000 sent back-to-back, with s_last_i on the third -> signal_wr_o in 4 consecutive cycles with those words then 7F900000; s_ready_o low on the sentinel cycle; frame_done_o pulses once.
- Hold signal_full_i=1 for 3 cycles during the second sample -> signal_fifo_o stays BE308D3D with signal_wr_o=1; no word is lost or duplicated; order is preserved.
- num_coeffs_i=0 -> only 7F900000 is emitted; num_coeffs_i=40 -> exactly 26 words plus the sentinel; a cfg_we_i during streaming leaves the table unchanged.
- rstn_i low mid-coefficient stream, then start_i again -> outputs 0 during reset; the new stream starts at table[n-1] of a zeroed table; no sentinel before reset.
- With MAC_FEEDER_NAN_SCRUB_EN, input 7F900000 -> 00000000 is forwarded and nan_err_o=1; without the macro -> 7F900000 is forwarded and nan_err_o=0.
